xadc_drp_responder: RTL and testbench

- Behavioural and synthesizable responder for the dynamic reconfiguration port (DRP) of the XADC block. This is the slave end of the DRP bus driven by our ADC controller.
- Holds a small register file:
  - two conversion result registers, VAUX3 at 0x13 and VAUX11 at 0x1b;
  - three writable configuration registers at 0x40-0x42.
- A free-running conversion sequencer refreshes the result registers from 12-bit sample inputs.
- Used as the ADC stand-in on FPGA builds without a hard XADC, and as the bench model for the controller.

---
 rtl/xadc_drp_pkg.sv | 21 ++
 rtl/xadc_conv_sequencer.sv | 55 +++++
 rtl/xadc_drp_responder.sv | 126 ++++++++++++
 tb/tb_xadc_drp_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/xadc_drp_pkg.sv
// Shared constants, DRP state encoding and result formatting for the XADC DRP responder.
package xadc_drp_pkg;

  localparam logic [6:0] ADDR_VAUX3  = 7'h13;
  localparam logic [6:0] ADDR_VAUX11 = 7'h1b;
  localparam logic [6:0] ADDR_CFG0   = 7'h40;
  localparam logic [6:0] ADDR_CFG1   = 7'h41;
  localparam logic [6:0] ADDR_CFG2   = 7'h42;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } drp_state_e;

  // Result registers hold the 12-bit sample left-justified; the low nibble is always zero.
  function automatic logic [15:0] pad12to16(input logic [11:0] sample);
    return {sample, 4'b0000};
  endfunction

endpackage

// File: rtl/xadc_conv_sequencer.sv
// Free-running conversion sequencer: alternates VAUX3/VAUX11 captures and holds both result registers.
module xadc_conv_sequencer
  import xadc_drp_pkg::*;
#(
  parameter int CONV_CYCLES = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [11:0] sample_a,
  input  logic [11:0] sample_b,
  output logic        eoc,
  output logic [4:0]  channel,
  output logic [15:0] vaux3,
  output logic [15:0] vaux11
);

  localparam int CW = $clog2(CONV_CYCLES);
  localparam logic [4:0] CH_A = ADDR_VAUX3[4:0];
  localparam logic [4:0] CH_B = ADDR_VAUX11[4:0];

  logic [CW-1:0] cnt;
  logic          cur_b;   // channel captured at the next wrap: 0 = VAUX3, 1 = VAUX11
  logic          wrap;

  // eoc is decoded from the counter so it marks the cycle whose closing edge writes the
  // result; a read accepted in that same cycle snapshots the value from before the update.
  assign wrap = !freeze && (cnt == CW'(CONV_CYCLES - 1));
  assign eoc  = wrap;

  // NOTE: sequential state uses non-blocking assignments only, so every register in this
  // block samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      cur_b   <= 1'b0;
      channel <= CH_A;
      // NOTE: the result registers are plain flops (two words, not a RAM), so clearing
      // them on reset costs nothing and keeps post-reset reads deterministic.
      vaux3   <= '0;
      vaux11  <= '0;
    end else if (!freeze) begin
      if (wrap) begin
        cnt <= '0;
        if (cur_b) vaux11 <= pad12to16(sample_b);
        else       vaux3  <= pad12to16(sample_a);
        channel <= cur_b ? CH_B : CH_A;
        cur_b   <= !cur_b;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/xadc_drp_responder.sv
// DRP slave for the XADC stand-in: fixed-latency read/write responder over results and config.
module xadc_drp_responder
  import xadc_drp_pkg::*;
#(
  parameter int          RD_LATENCY  = 4,
  parameter int          CONV_CYCLES = 26,
  parameter logic [15:0] CFG0_RST    = 16'h0000,
  parameter logic [15:0] CFG1_RST    = 16'h2000,
  parameter logic [15:0] CFG2_RST    = 16'h0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        den,
  input  logic        dwe,
  input  logic [6:0]  daddr,
  input  logic [15:0] di,
  output logic [15:0] do_data,
  output logic        drdy,
  output logic        busy,
  input  logic [11:0] sample_a,
  input  logic [11:0] sample_b,
  output logic        eoc,
  output logic [4:0]  channel,
  output logic        req_err
);

  drp_state_e  state, state_nxt;
  logic [3:0]  lat_cnt, lat_cnt_nxt;
  logic        accept;
  logic [6:0]  addr_q;
  logic        we_q;
  logic [15:0] di_q, snap_q;
  logic [15:0] cfg0, cfg1, cfg2;
  logic [15:0] vaux3, vaux11, rd_mux;

  xadc_conv_sequencer #(
    .CONV_CYCLES(CONV_CYCLES)
  ) u_seq (
    .clk     (clk),
    .rst     (rst),
    .freeze  (cfg1[15]),
    .sample_a(sample_a),
    .sample_b(sample_b),
    .eoc     (eoc),
    .channel (channel),
    .vaux3   (vaux3),
    .vaux11  (vaux11)
  );

  always_comb begin
    case (daddr)
      ADDR_VAUX3:  rd_mux = vaux3;
      ADDR_VAUX11: rd_mux = vaux11;
      ADDR_CFG0:   rd_mux = cfg0;
      ADDR_CFG1:   rd_mux = cfg1;
      ADDR_CFG2:   rd_mux = cfg2;
      default:     rd_mux = 16'h0000;
    endcase
  end

  // NOTE: every output of this block is given a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (den) begin
          accept = 1'b1;
          if (RD_LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt   = WAIT;
            lat_cnt_nxt = 4'(RD_LATENCY - 1);
          end
        end
      end
      WAIT: begin
        lat_cnt_nxt = lat_cnt - 4'd1;
        if (lat_cnt == 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign drdy    = (state == RESP);
  assign do_data = drdy ? snap_q : 16'h0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      di_q    <= '0;
      snap_q  <= '0;
      cfg0    <= CFG0_RST;
      cfg1    <= CFG1_RST;
      cfg2    <= CFG2_RST;
      req_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      if (accept) begin
        addr_q <= daddr;
        we_q   <= dwe;
        di_q   <= di;
        snap_q <= dwe ? 16'h0000 : rd_mux;
      end
      if (den && busy) req_err <= 1'b1;
      // Writes land at the end of the response cycle; anything outside 0x40-0x42 is dropped.
      if (state == RESP && we_q) begin
        case (addr_q)
          ADDR_CFG0: cfg0 <= di_q;
          ADDR_CFG1: cfg1 <= di_q;
          ADDR_CFG2: cfg2 <= di_q;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Directed self-checking bench for xadc_drp_responder at default parameters (latency 4, 26-cycle conversions).
module tb_xadc_drp_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        den = 1'b0;
  logic        dwe = 1'b0;
  logic [6:0]  daddr = '0;
  logic [15:0] di = '0;
  logic [15:0] do_data;
  logic        drdy, busy, eoc, req_err;
  logic [4:0]  channel;
  logic [11:0] sample_a = '0;
  logic [11:0] sample_b = '0;

  int n_cmp = 0;
  int n_bad = 0;

  xadc_drp_responder dut (
    .clk(clk), .rst(rst), .den(den), .dwe(dwe), .daddr(daddr), .di(di),
    .do_data(do_data), .drdy(drdy), .busy(busy),
    .sample_a(sample_a), .sample_b(sample_b),
    .eoc(eoc), .channel(channel), .req_err(req_err)
  );

  always #5 clk = ~clk;

  // Issues one request at the current negedge; returns the data seen with drdy and the
  // negedge count from the den cycle to drdy (-1 on timeout). Returns one negedge after
  // drdy, so the next call lands in the first cycle a new den is legal.
  task automatic do_txn(input logic we, input logic [6:0] addr, input logic [15:0] wdata,
                        input int inject_at, output logic [15:0] rdata, output int lat);
    int  n;
    bit  got;
    den = 1'b1; dwe = we; daddr = addr; di = wdata;
    n = 0; got = 0; rdata = 'x;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      den = (n == inject_at);
      if (drdy) begin
        got   = 1;
        rdata = do_data;
      end
    end
    den = 1'b0;
    lat = got ? n : -1;
    @(negedge clk);
  endtask

  // Waits for an eoc; with match=1 only one whose previously reported channel equals prev_ch.
  task automatic wait_eoc(input bit match, input logic [4:0] prev_ch, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (eoc && (!match || channel == prev_ch)) begin
        ok = 1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL eoc_timeout: no eoc within 200 cycles, required one");
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (drdy !== 1'b0)     begin n_bad++; $display("FAIL rst_drdy: got %b want 0", drdy); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (eoc !== 1'b0)      begin n_bad++; $display("FAIL rst_eoc: got %b want 0", eoc); end
    n_cmp++; if (channel !== 5'h13) begin n_bad++; $display("FAIL rst_channel: got %h want 13", channel); end
    n_cmp++; if (req_err !== 1'b0)  begin n_bad++; $display("FAIL rst_req_err: got %b want 0", req_err); end
    n_cmp++; if (do_data !== 16'h0) begin n_bad++; $display("FAIL rst_do_data: got %h want 0000", do_data); end
    rst = 1'b0;
  endtask

  task automatic test_config_read;
    logic [15:0] d; int lat; bit ok;
    sample_a = 12'hABC;
    sample_b = 12'h123;
    wait_eoc(1'b0, 5'h00, ok);
    @(negedge clk);
    n_cmp++; if (channel !== 5'h13) begin n_bad++; $display("FAIL first_channel: got %h want 13", channel); end
    do_txn(1'b0, 7'h13, 16'h0, 0, d, lat);
    n_cmp++; if (lat !== 4)          begin n_bad++; $display("FAIL rd13_latency: got %0d want 4", lat); end
    n_cmp++; if (d !== 16'hABC0)     begin n_bad++; $display("FAIL rd13_data: got %h want ABC0", d); end
    do_txn(1'b0, 7'h41, 16'h0, 0, d, lat);
    n_cmp++; if (d !== 16'h2000)     begin n_bad++; $display("FAIL rd41_reset: got %h want 2000", d); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d; int lat; bit ok;
    wait_eoc(1'b1, 5'h13, ok);
    @(negedge clk);
    n_cmp++; if (channel !== 5'h1b) begin n_bad++; $display("FAIL b2b_channel: got %h want 1b", channel); end
    do_txn(1'b0, 7'h1b, 16'h0, 0, d, lat);
    n_cmp++; if (d !== 16'h1230)    begin n_bad++; $display("FAIL b2b_rd1b: got %h want 1230", d); end
    do_txn(1'b0, 7'h13, 16'h0, 0, d, lat);
    n_cmp++; if (d !== 16'hABC0)    begin n_bad++; $display("FAIL b2b_rd13: got %h want ABC0", d); end
    n_cmp++; if (lat !== 4)         begin n_bad++; $display("FAIL b2b_latency: got %0d want 4", lat); end
    n_cmp++; if (req_err !== 1'b0)  begin n_bad++; $display("FAIL b2b_req_err: got %b want 0", req_err); end
  endtask

  task automatic test_write_read;
    logic [15:0] d; int lat;
    do_txn(1'b1, 7'h40, 16'h5A5A, 0, d, lat);
    n_cmp++; if (lat !== 4)         begin n_bad++; $display("FAIL wr40_latency: got %0d want 4", lat); end
    n_cmp++; if (d !== 16'h0000)    begin n_bad++; $display("FAIL wr40_do_data: got %h want 0000", d); end
    do_txn(1'b0, 7'h40, 16'h0, 0, d, lat);
    n_cmp++; if (d !== 16'h5A5A)    begin n_bad++; $display("FAIL rd40_back: got %h want 5A5A", d); end
    do_txn(1'b1, 7'h13, 16'hFFFF, 0, d, lat);
    n_cmp++; if (lat !== 4)         begin n_bad++; $display("FAIL wr13_drdy: got lat %0d want 4", lat); end
    do_txn(1'b0, 7'h13, 16'h0, 0, d, lat);
    n_cmp++; if (d !== 16'hABC0)    begin n_bad++; $display("FAIL wr13_ignored: got %h want ABC0", d); end
    do_txn(1'b0, 7'h22, 16'h0, 0, d, lat);
    n_cmp++; if (d !== 16'h0000 || lat !== 4) begin
      n_bad++; $display("FAIL rd_unmapped: got %h lat %0d want 0000 lat 4", d, lat);
    end
  endtask

  task automatic test_busy;
    logic [15:0] d; int lat; int extra;
    do_txn(1'b0, 7'h42, 16'h0, 1, d, lat);
    n_cmp++; if (lat !== 4)         begin n_bad++; $display("FAIL busy_latency: got %0d want 4", lat); end
    n_cmp++; if (d !== 16'h0400)    begin n_bad++; $display("FAIL busy_data: got %h want 0400", d); end
    n_cmp++; if (req_err !== 1'b1)  begin n_bad++; $display("FAIL busy_req_err: got %b want 1", req_err); end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (drdy) extra++;
    end
    n_cmp++; if (extra !== 0)       begin n_bad++; $display("FAIL busy_extra_drdy: got %0d want 0", extra); end
    do_txn(1'b0, 7'h41, 16'h0, 0, d, lat);
    n_cmp++; if (req_err !== 1'b1)  begin n_bad++; $display("FAIL busy_sticky: got %b want 1", req_err); end
  endtask

  task automatic test_collision_freeze;
    logic [15:0] d; int lat; bit ok; int n_eoc;
    wait_eoc(1'b1, 5'h13, ok);          // VAUX11 capture; the next one is VAUX3
    @(negedge clk);
    sample_a = 12'h777;
    wait_eoc(1'b1, 5'h1b, ok);          // this cycle's edge writes VAUX3
    do_txn(1'b0, 7'h13, 16'h0, 0, d, lat);
    n_cmp++; if (d !== 16'hABC0)    begin n_bad++; $display("FAIL collide_old: got %h want ABC0", d); end
    do_txn(1'b0, 7'h13, 16'h0, 0, d, lat);
    n_cmp++; if (d !== 16'h7770)    begin n_bad++; $display("FAIL collide_new: got %h want 7770", d); end
    do_txn(1'b1, 7'h41, 16'h8000, 0, d, lat);
    n_eoc = 0;
    for (int i = 0; i < 3 * 26; i++) begin
      @(negedge clk);
      if (eoc) n_eoc++;
    end
    n_cmp++; if (n_eoc !== 0)       begin n_bad++; $display("FAIL freeze_eoc: got %0d want 0", n_eoc); end
    do_txn(1'b0, 7'h41, 16'h0, 0, d, lat);
    n_cmp++; if (d !== 16'h8000)    begin n_bad++; $display("FAIL freeze_cfg1: got %h want 8000", d); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] d; int lat; int n_drdy;
    den = 1'b1; dwe = 1'b0; daddr = 7'h40;
    @(negedge clk); den = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (req_err !== 1'b0)  begin n_bad++; $display("FAIL midrst_req_err: got %b want 0", req_err); end
    n_cmp++; if (channel !== 5'h13) begin n_bad++; $display("FAIL midrst_channel: got %h want 13", channel); end
    n_drdy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (drdy) n_drdy++;
    end
    n_cmp++; if (n_drdy !== 0)      begin n_bad++; $display("FAIL midrst_drdy: got %0d want 0", n_drdy); end
    do_txn(1'b0, 7'h13, 16'h0, 0, d, lat);
    n_cmp++; if (d !== 16'h0000)    begin n_bad++; $display("FAIL midrst_vaux3: got %h want 0000", d); end
    do_txn(1'b0, 7'h1b, 16'h0, 0, d, lat);
    n_cmp++; if (d !== 16'h0000)    begin n_bad++; $display("FAIL midrst_vaux11: got %h want 0000", d); end
    do_txn(1'b0, 7'h40, 16'h0, 0, d, lat);
    n_cmp++; if (d !== 16'h0000)    begin n_bad++; $display("FAIL midrst_cfg0: got %h want 0000", d); end
    do_txn(1'b0, 7'h41, 16'h0, 0, d, lat);
    n_cmp++; if (d !== 16'h2000)    begin n_bad++; $display("FAIL midrst_cfg1: got %h want 2000", d); end
    do_txn(1'b0, 7'h42, 16'h0, 0, d, lat);
    n_cmp++; if (d !== 16'h0400)    begin n_bad++; $display("FAIL midrst_cfg2: got %h want 0400", d); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_config_read();
    test_back_to_back();
    test_write_read();
    test_busy();
    test_collision_freeze();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
